cpu_oam_dma: RTL and testbench

- Sits between the 6502 core's memory port and the system bus, downstream of the core.
- A CPU write of the page number to $4014 makes the block stall the core and copy 256 bytes from CPU page {page, 00..FF} to the PPU OAMDATA register ($2004).
- One byte moves per read/write cycle pair. It then returns bus ownership to the core.
- When idle it is a transparent pass-through of the core's addr / mem_r_en / w_data.

---
 rtl/cpu_oam_dma.sv | 123 ++++++++++++
 tb/tb_cpu_oam_dma.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_oam_dma.sv
// OAM DMA engine between the 6502 core and the system bus. A core write to the
// DMA register stalls the core and copies one 256-byte page into OAMDATA.
module cpu_oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_mem_r_en,
    input  logic [7:0]  cpu_w_data,
    output logic        cpu_stall,
    output logic [15:0] bus_addr,
    output logic        bus_mem_r_en,
    output logic [7:0]  bus_w_data,
    input  logic [7:0]  bus_r_data,
    output logic        dma_active
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t      state_r;
    logic [7:0]  page_r;
    logic [7:0]  idx_r;
    logic [7:0]  data_buf_r;
    logic        parity_r;
    logic        trigger_s;

    // A write (not a read) of the DMA register while idle starts a transfer.
    always_comb begin
        trigger_s = 1'b0;
        if ((cpu_addr == DMA_REG_ADDR) && (cpu_mem_r_en == 1'b0)) begin
            trigger_s = 1'b1;
        end else begin
            trigger_s = 1'b0;
        end
    end

    // Transfer sequencer; parity tracks the CPU get/put cycle so READ lands on even cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            page_r     <= 8'h00;
            idx_r      <= 8'h00;
            data_buf_r <= 8'h00;
            parity_r   <= 1'b0;
        end else begin
            parity_r <= ~parity_r;
            case (state_r)
                IDLE: begin
                    if (trigger_s) begin
                        page_r  <= cpu_w_data;
                        idx_r   <= 8'h00;
                        state_r <= HALT;
                    end
                end
                HALT: begin
                    state_r <= parity_r ? READ : ALIGN;
                end
                ALIGN: begin
                    state_r <= READ;
                end
                READ: begin
                    data_buf_r <= bus_r_data;
                    state_r    <= WRITE;
                end
                WRITE: begin
                    if (idx_r == 8'hFF) begin
                        idx_r   <= 8'h00;
                        state_r <= IDLE;
                    end else begin
                        idx_r   <= idx_r + 8'd1;
                        state_r <= READ;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Bus ownership mux: the core owns the bus only while idle.
    always_comb begin
        cpu_stall    = 1'b1;
        dma_active   = 1'b1;
        bus_addr     = {page_r, 8'h00};
        bus_mem_r_en = 1'b1;
        bus_w_data   = data_buf_r;
        case (state_r)
            IDLE: begin
                cpu_stall    = 1'b0;
                dma_active   = 1'b0;
                bus_addr     = cpu_addr;
                bus_mem_r_en = cpu_mem_r_en;
                bus_w_data   = cpu_w_data;
            end
            HALT, ALIGN: begin
                bus_addr     = {page_r, 8'h00};
                bus_mem_r_en = 1'b1;
            end
            READ: begin
                bus_addr     = {page_r, idx_r};
                bus_mem_r_en = 1'b1;
            end
            WRITE: begin
                bus_addr     = OAMDATA_ADDR;
                bus_mem_r_en = 1'b0;
            end
            default: begin
                bus_addr     = {page_r, 8'h00};
                bus_mem_r_en = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_oam_dma.sv
// Directed bench for cpu_oam_dma: a memory model feeds reads, and a scoreboard
// holds the expected OAM write data and source address for every DMA write.
`timescale 1ns/1ps
module tb_cpu_oam_dma;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cpu_addr;
    logic        cpu_mem_r_en;
    logic [7:0]  cpu_w_data;
    logic        cpu_stall;
    logic [15:0] bus_addr;
    logic        bus_mem_r_en;
    logic [7:0]  bus_w_data;
    logic [7:0]  bus_r_data;
    logic        dma_active;

    logic [7:0]  mem [0:65535];
    logic [7:0]  exp_data_q [$];
    logic [15:0] exp_addr_q [$];
    logic [15:0] last_raddr = 16'h0000;
    logic        tb_par;
    logic        p0;
    int          tests = 0;
    int          fails = 0;
    int          stall_cnt = 0;
    int          wr_cnt = 0;

    cpu_oam_dma dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cpu_addr     (cpu_addr),
        .cpu_mem_r_en (cpu_mem_r_en),
        .cpu_w_data   (cpu_w_data),
        .cpu_stall    (cpu_stall),
        .bus_addr     (bus_addr),
        .bus_mem_r_en (bus_mem_r_en),
        .bus_w_data   (bus_w_data),
        .bus_r_data   (bus_r_data),
        .dma_active   (dma_active)
    );

    always #5 clock = ~clock;
    assign bus_r_data = mem[bus_addr];

    // Reference cycle parity, independent of the DUT.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) tb_par <= 1'b0;
        else          tb_par <= ~tb_par;
    end

    function automatic logic [7:0] pat(input logic [7:0] p);
        return (p == 8'h02) ? 8'h5A : (p ^ 8'hC3);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Monitor: pass-through when idle, scoreboard pop on every DMA write.
    always @(negedge clock) begin
        check("active_eq_stall", {31'd0, dma_active}, {31'd0, cpu_stall});
        if (cpu_stall) stall_cnt++;
        if (!dma_active) begin
            check("passthru", {7'd0, bus_addr, bus_mem_r_en, bus_w_data},
                              {7'd0, cpu_addr, cpu_mem_r_en, cpu_w_data});
        end else if (bus_mem_r_en) begin
            last_raddr = bus_addr;
        end else begin
            wr_cnt++;
            check("wr_addr", {16'd0, bus_addr}, {16'd0, 16'h2004});
            if (exp_data_q.size() == 0) begin
                check("unexpected_wr", 32'd1, 32'd0);
            end else begin
                check("wr_data", {24'd0, bus_w_data}, {24'd0, exp_data_q.pop_front()});
                check("rd_addr", {16'd0, last_raddr}, {16'd0, exp_addr_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_bus();
        cpu_addr     = 16'h0000;
        cpu_mem_r_en = 1'b1;
        cpu_w_data   = 8'h00;
    endtask

    task automatic start_dma(input logic [7:0] p);
        for (int i = 0; i < 256; i++) begin
            exp_addr_q.push_back({p, i[7:0]});
            exp_data_q.push_back(i[7:0] ^ pat(p));
        end
        stall_cnt    = 0;
        wr_cnt       = 0;
        cpu_addr     = 16'h4014;
        cpu_mem_r_en = 1'b0;
        cpu_w_data   = p;
        #3;
        check("trigger_passthru", {7'd0, bus_addr, bus_mem_r_en, bus_w_data},
                                  {7'd0, 16'h4014, 1'b0, p});
        check("trigger_no_stall", {31'd0, cpu_stall}, 32'd0);
        step();
        idle_bus();
    endtask

    task automatic finish_dma(input int exp_len);
        int n;
        n = 0;
        check("stall_rise", {31'd0, cpu_stall}, 32'd1);
        while (cpu_stall && n < 600) begin
            step();
            n++;
        end
        check("stall_len", stall_cnt, exp_len);
        check("wr_count", wr_cnt, 256);
        check("queue_empty", exp_data_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a] = a[7:0] ^ pat(a[15:8]);
        end
        idle_bus();
        step();
        step();
        check("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_active", {31'd0, dma_active}, 32'd0);
        reset_n = 1'b1;

        // Even trigger, page $02.
        if (tb_par) step();
        start_dma(8'h02);
        finish_dma(513);

        // Odd trigger, page $02.
        if (!tb_par) step();
        start_dma(8'h02);
        finish_dma(514);

        // Non-triggering accesses.
        step();
        cpu_addr = 16'h4014; cpu_mem_r_en = 1'b1; cpu_w_data = 8'h02;
        step();
        check("rd4014_no_stall", {31'd0, cpu_stall}, 32'd0);
        cpu_addr = 16'h4013; cpu_mem_r_en = 1'b0; cpu_w_data = 8'h02;
        step();
        check("wr4013_no_stall", {31'd0, cpu_stall}, 32'd0);
        cpu_addr = 16'h4015; cpu_mem_r_en = 1'b0; cpu_w_data = 8'h02;
        step();
        check("wr4015_no_stall", {31'd0, cpu_stall}, 32'd0);
        idle_bus();
        step();
        check("non_trigger_idle", {31'd0, cpu_stall}, 32'd0);

        // Reset abort after the write with idx=100.
        start_dma(8'h02);
        for (int n = 0; n < 400 && wr_cnt < 101; n++) step();
        cpu_addr = 16'h1234; cpu_mem_r_en = 1'b1; cpu_w_data = 8'h77;
        reset_n = 1'b0;
        #1;
        check("abort_stall", {31'd0, cpu_stall}, 32'd0);
        check("abort_active", {31'd0, dma_active}, 32'd0);
        check("abort_mirror", {7'd0, bus_addr, bus_mem_r_en, bus_w_data},
                              {7'd0, 16'h1234, 1'b1, 8'h77});
        exp_data_q.delete();
        exp_addr_q.delete();
        idle_bus();
        step();
        step();
        reset_n = 1'b1;
        step();
        p0 = tb_par;
        start_dma(8'h03);
        finish_dma(p0 ? 514 : 513);

        // Back-to-back: second trigger on the first idle cycle.
        p0 = tb_par;
        start_dma(8'h07);
        finish_dma(p0 ? 514 : 513);
        p0 = tb_par;
        start_dma(8'h08);
        finish_dma(p0 ? 514 : 513);

        // Input isolation: core keeps writing $FF to $4014 mid-transfer.
        step();
        p0 = tb_par;
        start_dma(8'h02);
        cpu_addr = 16'h4014; cpu_mem_r_en = 1'b0; cpu_w_data = 8'hFF;
        for (int n = 0; n < 200; n++) step();
        idle_bus();
        finish_dma(p0 ? 514 : 513);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
